multi_tone_gen: RTL
===================

# multi_tone_gen

Parametrised multi-channel square-wave tone generator with per-note duration timing and a 1-bit output mixer. It is the successor to the single-channel free-running tone block. Each channel plays a note of a given frequency (Hz) for a given duration (ms) after a start pulse, then reports completion. The game sequencer drives it directly, and `sound` feeds the speaker pin.

## Interface
- NUM_CH, 2: number of independent tone channels (1..8)
- FREQ_W, 10: frequency field width, Hz
- TPM_W, 6: clock-ticks-per-millisecond width
- DUR_W, 12: duration field width, ms

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ticks_per_milli  in  TPM_W  clock cycles per ms, shared by all channels
- freq  in  NUM_CH*FREQ_W  per-channel frequency, channel i at [i*FREQ_W +: FREQ_W]; 0 = rest
- dur_ms  in  NUM_CH*DUR_W  per-channel duration, channel i at [i*DUR_W +: DUR_W]
- start  in  NUM_CH  per-channel start/retrigger strobe, sampled every cycle
- busy  out  NUM_CH  channel in PLAY
- done  out  NUM_CH  one-cycle pulse on note completion
- wave  out  NUM_CH  per-channel square wave
- sound  out  1  mixed speaker output

## Operation
- Prescaler:
  - Free-running counter, cleared by rst.
  - `ms_tick` pulses one cycle when the count equals ticks_per_milli-1, then the count wraps to 0.
  - ticks_per_milli==0: no ms_tick.
- half = ticks_per_milli*500, computed at width TPM_W+9.
- Phase accumulator per channel, width TPM_W+FREQ_W+10.
- Per-channel FSM, IDLE / PLAY:
  - IDLE + start[i], dur≠0, ticks_per_milli≠0:
    - latch freq and dur into note registers
    - clear accumulator and wave
    - go to PLAY
  - IDLE + start[i] with dur==0 or ticks_per_milli==0: stay IDLE, pulse done[i] next cycle.
  - PLAY + start[i]: retrigger.
    - Re-latch freq/dur, clear accumulator, force wave 0.
    - Stay in PLAY; no done pulse.
  - PLAY, latched freq≠0, each cycle:
    - acc ≥ half: toggle wave, acc ← acc+freq−half
    - else: acc ← acc+freq
  - PLAY, latched freq==0 (rest): wave held 0, duration still counts.
  - PLAY, on ms_tick: decrement the remaining count.
    - When ms_tick arrives with remaining==1: go to IDLE, pulse done, force wave 0.
  - Latched values are used for the whole note; input changes after start have no effect.
- Channels are fully independent; simultaneous starts/dones on several channels are legal.
- Mixer without the macro: sound ← OR of wave, registered.

## Timing
- Reset values: busy=0, done=0, wave=0, sound=0, all accumulators/counters 0.
- start sampled at cycle t:
  - busy=1 from t+1
  - first PLAY cycle is t+1
- Wave period = ticks_per_milli*1000/freq cycles, average; jitter ±1 cycle.
- First wave edge no earlier than ceil(half/freq)+1 cycles after entering PLAY.
- Duration: ms_tick phase is not reset by start, so busy lasts between (dur−1)*tpm+1 and dur*tpm cycles.
- done is high in the first IDLE cycle, coincident with busy falling.
- wave and busy change on the same edge at note end.
- sound lags wave by 1 cycle.
- rst mid-note: all channels to IDLE at the next edge, no done pulse.

## Configuration
- TONE_SIGMA_DELTA_EN defined: sound is a first-order sigma-delta mix.
  - cnt = number of wave bits high.
  - m ← m+cnt each cycle.
  - If the new m ≥ NUM_CH: sound=1 and m ← m+cnt−NUM_CH.
  - Otherwise sound=0.
  - m has width clog2(2*NUM_CH+1) and is reset to 0.
- Undefined: sound = registered OR of wave. No mixer accumulator is present.

## Test plan
- tpm=2, ch0 freq=500, dur=10 → wave0 toggles every 2 cycles (period 4); busy0 high 19–20 cycles; done0 single pulse; wave0=0 after.
- Ch0 freq=0, dur=3, tpm=2 → wave0 stays 0; busy0 high 5–6 cycles; done0 pulses once.
- Start with dur=0 → busy stays 0; done pulses exactly one cycle after start.
- Retrigger ch0 mid-note with freq=250 → wave0 forced 0 next cycle; new period 8 cycles; no done between notes.
- Both channels started the same cycle with equal params → identical busy/done/wave; rst asserted mid-note → everything 0 next cycle, no done.
- TONE_SIGMA_DELTA_EN, NUM_CH=2, wave0 held high (large half), ch1 idle → sound alternates 1,0 (50% density). Without the macro → sound constant 1.

Source files
------------

// File: rtl/multi_tone_gen.sv
// Multi-channel square-wave tone generator with per-note millisecond duration and 1-bit mixer.
// Define TONE_SIGMA_DELTA_EN to replace the OR mixer with a first-order sigma-delta mixer.
module multi_tone_gen #(
    parameter int NUM_CH = 2,
    parameter int FREQ_W = 10,
    parameter int TPM_W  = 6,
    parameter int DUR_W  = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TPM_W-1:0]           ticks_per_milli,
    input  logic [NUM_CH*FREQ_W-1:0]   freq,
    input  logic [NUM_CH*DUR_W-1:0]    dur_ms,
    input  logic [NUM_CH-1:0]          start,
    output logic [NUM_CH-1:0]          busy,
    output logic [NUM_CH-1:0]          done,
    output logic [NUM_CH-1:0]          wave,
    output logic                       sound
);

    localparam int HALF_W = TPM_W + 9;
    localparam int ACC_W  = TPM_W + FREQ_W + 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    logic [TPM_W-1:0]  pres_r;
    logic              tpm_zero_s;
    logic              ms_tick_s;
    logic [HALF_W-1:0] half_s;
    logic [NUM_CH-1:0] wave_vec_s;
    logic              sound_r;

    assign tpm_zero_s = (ticks_per_milli == {TPM_W{1'b0}});
    assign ms_tick_s  = !tpm_zero_s && (pres_r == (ticks_per_milli - TPM_W'(1)));
    assign half_s     = HALF_W'(ticks_per_milli) * HALF_W'(500);

    // Shared millisecond prescaler; its phase is never disturbed by note starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            pres_r <= {TPM_W{1'b0}};
        end else if (ms_tick_s) begin
            pres_r <= {TPM_W{1'b0}};
        end else begin
            pres_r <= pres_r + TPM_W'(1);
        end
    end

    genvar i;
    for (i = 0; i < NUM_CH; i++) begin : g_ch
        logic [FREQ_W-1:0] freq_in_s;
        logic [DUR_W-1:0]  dur_in_s;
        logic              start_ok_s;

        state_t            state_r, state_nx_s;
        logic [FREQ_W-1:0] note_freq_r, note_freq_nx_s;
        logic [DUR_W-1:0]  rem_r, rem_nx_s;
        logic [ACC_W-1:0]  acc_r, acc_nx_s;
        logic              wave_r, wave_nx_s;
        logic              done_r, done_nx_s;

        assign freq_in_s  = freq[i*FREQ_W +: FREQ_W];
        assign dur_in_s   = dur_ms[i*DUR_W +: DUR_W];
        assign start_ok_s = (dur_in_s != {DUR_W{1'b0}}) && !tpm_zero_s;

        // Next-state logic: start/retrigger, phase accumulation and duration countdown.
        always_comb begin
            state_nx_s     = state_r;
            note_freq_nx_s = note_freq_r;
            rem_nx_s       = rem_r;
            acc_nx_s       = acc_r;
            wave_nx_s      = wave_r;
            done_nx_s      = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    wave_nx_s = 1'b0;
                    if (start[i] && start_ok_s) begin
                        state_nx_s     = ST_PLAY;
                        note_freq_nx_s = freq_in_s;
                        rem_nx_s       = dur_in_s;
                        acc_nx_s       = {ACC_W{1'b0}};
                    end else if (start[i]) begin
                        done_nx_s = 1'b1;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (start[i]) begin
                        // A retrigger that cannot play ends the note rather than hanging in PLAY.
                        acc_nx_s  = {ACC_W{1'b0}};
                        wave_nx_s = 1'b0;
                        if (start_ok_s) begin
                            note_freq_nx_s = freq_in_s;
                            rem_nx_s       = dur_in_s;
                        end else begin
                            state_nx_s = ST_IDLE;
                            done_nx_s  = 1'b1;
                        end
                    end else begin
                        if (note_freq_r == {FREQ_W{1'b0}}) begin
                            wave_nx_s = 1'b0;
                        end else if (acc_r >= ACC_W'(half_s)) begin
                            wave_nx_s = ~wave_r;
                            acc_nx_s  = acc_r + ACC_W'(note_freq_r) - ACC_W'(half_s);
                        end else begin
                            acc_nx_s = acc_r + ACC_W'(note_freq_r);
                        end
                        if (ms_tick_s && (rem_r == DUR_W'(1))) begin
                            state_nx_s = ST_IDLE;
                            done_nx_s  = 1'b1;
                            wave_nx_s  = 1'b0;
                        end else if (ms_tick_s) begin
                            rem_nx_s = rem_r - DUR_W'(1);
                        end else begin
                            rem_nx_s = rem_r;
                        end
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    wave_nx_s  = 1'b0;
                end
            endcase
        end

        // Channel state registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r     <= ST_IDLE;
                note_freq_r <= {FREQ_W{1'b0}};
                rem_r       <= {DUR_W{1'b0}};
                acc_r       <= {ACC_W{1'b0}};
                wave_r      <= 1'b0;
                done_r      <= 1'b0;
            end else begin
                state_r     <= state_nx_s;
                note_freq_r <= note_freq_nx_s;
                rem_r       <= rem_nx_s;
                acc_r       <= acc_nx_s;
                wave_r      <= wave_nx_s;
                done_r      <= done_nx_s;
            end
        end

        assign busy[i]       = (state_r == ST_PLAY);
        assign done[i]       = done_r;
        assign wave[i]       = wave_r;
        assign wave_vec_s[i] = wave_r;
    end

`ifdef TONE_SIGMA_DELTA_EN
    localparam int SD_W = $clog2(2*NUM_CH+1);

    function automatic logic [SD_W-1:0] count_ones(input logic [NUM_CH-1:0] v);
        logic [SD_W-1:0] cnt;
        cnt = {SD_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            cnt = cnt + SD_W'(v[k]);
        end
        return cnt;
    endfunction

    logic [SD_W-1:0] mix_r;
    logic [SD_W-1:0] mix_sum_s;

    assign mix_sum_s = mix_r + count_ones(wave_vec_s);

    // First-order sigma-delta: output density tracks the fraction of channels high.
    always_ff @(posedge clk) begin
        if (rst) begin
            mix_r   <= {SD_W{1'b0}};
            sound_r <= 1'b0;
        end else if (mix_sum_s >= SD_W'(NUM_CH)) begin
            mix_r   <= mix_sum_s - SD_W'(NUM_CH);
            sound_r <= 1'b1;
        end else begin
            mix_r   <= mix_sum_s;
            sound_r <= 1'b0;
        end
    end
`else
    // OR mixer, registered so sound lags the channel waves by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sound_r <= 1'b0;
        end else begin
            sound_r <= |wave_vec_s;
        end
    end
`endif

    assign sound = sound_r;

endmodule
